// File: rtl/btn_scan_scheduler_pkg.sv
// Shared types for the scanned button debouncer: scan FSM encoding and a
// width helper for index fields that stays legal for a single-button bank.
package midi_btn_pkg;

    typedef enum logic [0:0] {
        SC_IDLE = 1'b0,
        SC_SCAN = 1'b1
    } scan_state_t;

    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_scan_scheduler_if.sv
// Press/release event stream from the button scanner to the MIDI message logic.
// The scanner drives through the master modport; the consumer uses slave.
interface btn_scan_scheduler_if #(
    parameter int ID_W = 3
);
    logic            evt_valid;
    logic            evt_ready;
    logic [ID_W-1:0] evt_id;
    logic            evt_press;

    modport master (output evt_valid, output evt_id, output evt_press, input evt_ready);
    modport slave  (input evt_valid, input evt_id, input evt_press, output evt_ready);
endinterface

// File: rtl/btn_scan_scheduler_fifo.sv
// Event queue for the button scanner; pointers carry an extra wrap bit so a
// full queue and an empty queue are told apart without a separate counter.
module btn_evt_fifo #(
    parameter int  DEPTH = 4,
    parameter type evt_t = logic [3:0]
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  evt_t din,
    input  logic pop,
    output evt_t dout,
    output logic full,
    output logic empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    evt_t          r_mem [DEPTH];
    evt_t          r_last;
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic [AW-1:0] w_wr_addr;
    logic [AW-1:0] w_rd_addr;
    logic          w_do_pop;
    logic          w_do_push;

    assign w_wr_addr = r_wr_ptr[AW-1:0];
    assign w_rd_addr = r_rd_ptr[AW-1:0];
    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (w_wr_addr == w_rd_addr);
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);
    // Once drained, the head shows the last event handed out instead of stale storage
    assign dout      = empty ? r_last : r_mem[w_rd_addr];

    // Event storage
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[w_wr_addr] <= din;
        end
    end

    // Queue pointers and last-popped event
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_last   <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
                r_last   <= r_mem[w_rd_addr];
            end
        end
    end

endmodule

// File: rtl/btn_scan_scheduler.sv
// Round-robin debouncer: one counter/compare engine visits each button once per
// scan tick and merges accepted level changes into a single event stream.
module btn_scan_scheduler
    import midi_btn_pkg::*;
#(
    parameter int NUM_BTN      = 8,
    parameter int TICK_DIV     = 5000,
    parameter int STABLE_TICKS = 20,
    parameter int ACTIVE_LOW   = 1,
    parameter int REPORT_REL   = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_BTN-1:0]    btn,
    output logic [NUM_BTN-1:0]    btn_state,
    btn_scan_scheduler_if.master  evt,
    output logic                  ovf,
    input  logic                  ovf_clr
);
    localparam int ID_W = id_width(NUM_BTN);
    localparam int CW   = $clog2(STABLE_TICKS + 1);
    localparam int TW   = $clog2(TICK_DIV);
    localparam logic [NUM_BTN-1:0] SYNC_IDLE = (ACTIVE_LOW != 0) ? {NUM_BTN{1'b1}} : {NUM_BTN{1'b0}};

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic            press;
    } btn_evt_t;

    if (TICK_DIV < NUM_BTN + 2) begin : g_bad_tick_div
        $error("btn_scan_scheduler: TICK_DIV must be at least NUM_BTN+2");
    end
    if (STABLE_TICKS < 1) begin : g_bad_stable
        $error("btn_scan_scheduler: STABLE_TICKS must be at least 1");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("btn_scan_scheduler: FIFO_DEPTH must be a power of two");
    end

    logic [NUM_BTN-1:0] r_sync1, r_sync2, r_btn_state;
    logic [NUM_BTN-1:0] w_pressed;
    logic [CW-1:0]      r_cnt [NUM_BTN];
    logic [TW-1:0]      r_tick_cnt;
    logic [ID_W-1:0]    r_idx;
    scan_state_t        r_state, w_state_nxt;
    logic               r_ovf;
    logic               w_tick, w_last, w_scan, w_s, w_differ, w_accept, w_push;
    logic               w_pop, w_full, w_empty;
    logic [CW-1:0]      w_cnt_inc;
    btn_evt_t           w_din, w_head;

    // Two-flop synchroniser, parked at the released pin level in reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= SYNC_IDLE;
            r_sync2 <= SYNC_IDLE;
        end else begin
            r_sync1 <= btn;
            r_sync2 <= r_sync1;
        end
    end

    assign w_pressed = (ACTIVE_LOW != 0) ? ~r_sync2 : r_sync2;
    assign w_tick    = (r_tick_cnt == TW'(TICK_DIV - 1));
    assign w_last    = (r_idx == ID_W'(NUM_BTN - 1));

    // Scan tick divider
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
        end
    end

    // Scan FSM next-state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SC_IDLE: begin
                if (w_tick) w_state_nxt = SC_SCAN;
                else        w_state_nxt = SC_IDLE;
            end
            SC_SCAN: begin
                if (w_last) w_state_nxt = SC_IDLE;
                else        w_state_nxt = SC_SCAN;
            end
            default: w_state_nxt = SC_IDLE;
        endcase
    end

    // Scan FSM state and button index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SC_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == SC_IDLE) begin
                r_idx <= '0;
            end else if (!w_last) begin
                r_idx <= r_idx + ID_W'(1);
            end
        end
    end

    assign w_scan    = (r_state == SC_SCAN);
    assign w_s       = w_pressed[r_idx];
    assign w_differ  = w_scan && (w_s != r_btn_state[r_idx]);
    assign w_cnt_inc = r_cnt[r_idx] + CW'(1);
    assign w_accept  = w_differ && (w_cnt_inc == CW'(STABLE_TICKS));
    assign w_push    = w_accept && (w_s || (REPORT_REL != 0));
    assign w_din     = '{id: r_idx, press: w_s};

    // Shared debounce step for the button under the scan index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_btn_state <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (w_scan) begin
            if (!w_differ) begin
                r_cnt[r_idx] <= '0;
            end else if (w_accept) begin
                r_cnt[r_idx]       <= '0;
                r_btn_state[r_idx] <= w_s;
            end else begin
                r_cnt[r_idx] <= w_cnt_inc;
            end
        end
    end

    assign w_pop = evt.evt_valid & evt.evt_ready;

    // Sticky drop flag; a clear in the same cycle as a drop wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end else if (w_push && w_full && !w_pop) begin
            r_ovf <= 1'b1;
        end
    end

    btn_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .evt_t (btn_evt_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .din   (w_din),
        .pop   (w_pop),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    assign evt.evt_valid = ~w_empty;
    assign evt.evt_id    = w_head.id;
    assign evt.evt_press = w_head.press;
    assign btn_state     = r_btn_state;
    assign ovf           = r_ovf;

endmodule
